// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one fetch at a time over
// req/ack, holds the returned word until accepted, and handles redirects.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_error
);

  typedef enum logic [2:0] {IDLE, FETCH, VALID, DRAIN, HALT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] instr_pc_reg, instr_pc_next;
  logic [31:0] target_reg, target_next;
  logic        err_reg, err_next;
  logic        redir_ok, redir_bad;

  // Once an error is latched every further redirect is ignored.
  assign redir_ok  = redirect && !err_reg && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect && !err_reg && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      instr_reg    <= 32'h0;
      instr_pc_reg <= 32'h0;
      target_reg   <= 32'h0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
      target_reg   <= target_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    target_next   = target_reg;
    err_next      = err_reg | redir_bad;

    case (state_reg)
      IDLE: begin
        if (redir_bad) begin
          state_next = HALT;
        end else begin
          state_next = FETCH;
          if (redir_ok) pc_next = redirect_pc;
        end
      end

      FETCH: begin
        // An unacked request cannot be withdrawn, so redirects park in DRAIN.
        if (redir_bad) begin
          state_next = mem_ack ? HALT : DRAIN;
        end else if (redir_ok) begin
          if (mem_ack) begin
            pc_next = redirect_pc;
          end else begin
            target_next = redirect_pc;
            state_next  = DRAIN;
          end
        end else if (mem_ack) begin
          instr_next    = mem_rdata;
          instr_pc_next = pc_reg;
          pc_next       = pc_reg + 32'd4;
          state_next    = VALID;
        end
      end

      VALID: begin
        if (redir_bad) begin
          state_next = HALT;
        end else if (redir_ok) begin
          pc_next    = redirect_pc;
          state_next = FETCH;
        end else if (instr_ready) begin
          state_next = FETCH;
        end
      end

      DRAIN: begin
        if (redir_ok) target_next = redirect_pc;
        if (mem_ack) begin
          if (err_reg || redir_bad) begin
            state_next = HALT;
          end else begin
            pc_next    = redir_ok ? redirect_pc : target_reg;
            state_next = FETCH;
          end
        end
      end

      HALT:    state_next = HALT;
      default: state_next = HALT;
    endcase
  end

  assign mem_req     = (state_reg == FETCH) || (state_reg == DRAIN);
  assign mem_addr    = pc_reg;
  assign instr_valid = (state_reg == VALID);
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign fetch_error = err_reg;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller sitting between the program counter and the instruction memory. It owns the PC, issues one fetch at a time over a req/ack handshake, and holds each returned instruction in an output register until the decoder/control unit accepts it. It also applies branch/jump redirects with correct discard of in-flight fetches, and halts on a misaligned target.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- `clk`  in  1  rising-edge clock for all state.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  fetch request to instruction memory.
- `mem_addr`  out  32  fetch byte address; stable while `mem_req`=1.
- `mem_ack`  in  1  `mem_rdata` valid this cycle; may be asserted in the same cycle as `mem_req`.
- `mem_rdata`  in  32  returned instruction word.
- `instr_valid`  out  1  `instr`/`instr_pc` hold a valid instruction.
- `instr`  out  32  held instruction word.
- `instr_pc`  out  32  address the held instruction was fetched from.
- `instr_ready`  in  1  consumer accepts `instr` when `instr_valid`=1.
- `redirect`  in  1  one-cycle pulse: resume fetch at `redirect_pc`.
- `redirect_pc`  in  32  redirect target.
- `fetch_error`  out  1  sticky: misaligned redirect seen; fetch halted.

## Operation
- Registers: `pc`, `instr`, `instr_pc`, `target`, FSM state, `err`.
- States: IDLE, FETCH, VALID, DRAIN, HALT. Reset state IDLE.
- `mem_req`=1 only in FETCH and DRAIN; `instr_valid`=1 only in VALID; `fetch_error`=`err`. All outputs decoded from registers (no input-to-output paths).
- `mem_addr` = `pc` in all states.
- IDLE: -> FETCH unconditionally.
- FETCH: on `mem_ack` capture `instr`<=`mem_rdata`, `instr_pc`<=`pc`, `pc`<=`pc`+4, -> VALID; else stay.
- VALID: on `instr_ready` -> FETCH; else hold all outputs.
- Redirect (aligned, `redirect_pc[1:0]`==0), highest priority:
  - IDLE/VALID: `pc`<=`redirect_pc`, -> FETCH. In VALID with `instr_ready`=1 the handshake still completes; flushing the accepted wrong-path instruction is the consumer's job.
  - FETCH with `mem_ack`=1: returned data discarded, `pc`<=`redirect_pc`, -> FETCH.
  - FETCH with `mem_ack`=0: `target`<=`redirect_pc`, -> DRAIN (request cannot be withdrawn).
  - DRAIN: `target`<=`redirect_pc` (latest wins).
- DRAIN: `mem_req`/`mem_addr` held; on `mem_ack` data discarded, `pc`<=`target`, -> FETCH (or -> HALT if `err`).
- Misaligned redirect: `err`<=1 next edge. If a request is outstanding without ack -> DRAIN, then HALT on ack; otherwise -> HALT directly. Later redirects ignored once `err`=1.
- HALT: `mem_req`=0, `instr_valid`=0; exit only via reset.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- `rst_n` low at any time (including mid-handshake): immediate return to IDLE; in-flight `mem_ack` after reset is not expected and is ignored outside FETCH/DRAIN.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=0, `instr_pc`=0, `fetch_error`=0.
- First `mem_req` one cycle after `rst_n` deassertion (IDLE cycle).
- Zero-wait memory (ack in request cycle): `instr_valid` rises the cycle after; with `instr_ready` tied high, one instruction every 2 cycles.
- N-cycle memory wait: `instr_valid` rises 1 cycle after the ack cycle.
- Redirect to first request at target: 1 cycle if nothing outstanding; otherwise 1 cycle after the draining ack.
- `mem_ack` outside FETCH/DRAIN is ignored.

## Test plan
- Reset, `RESET_PC`=0, zero-wait memory, `instr_ready`=1 -> `mem_addr` sequence 0,4,8,12; `instr_valid` every other cycle with matching `instr_pc`.
- Memory acks 3 cycles late, `instr_ready` low 5 cycles in VALID -> `mem_addr` stable while waiting; `instr`/`instr_pc` stable until accept; no request issued in VALID.
- Redirect to 0x100 while FETCH is waiting on ack -> `mem_addr` held until ack; data discarded (no `instr_valid`); next request at 0x100. Second redirect to 0x200 during DRAIN -> next request at 0x200.
- Redirect to 0x40 in the same cycle as zero-wait ack of 0x8 -> 0x8 never presented; next request 0x40.
- Redirect to 0x102 -> `fetch_error`=1 next cycle; `mem_req` and `instr_valid` stay 0; later aligned redirects ignored; `rst_n` pulse clears error and fetch restarts at `RESET_PC`.
- `RESET_PC`=32'hFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; `rst_n` asserted mid-request -> `mem_req` drops immediately and fetch restarts from `RESET_PC`.
